dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 116 +++++++++++
 tb/tb_dmem_arbiter.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter in front of a single-port data
// memory (asynchronous read, synchronous write). Each transaction takes
// three cycles: IDLE (grant and latch), ACCESS (memory cycle) and RESP
// (ack strobe).
module dmem_arbiter #(
    parameter int DATA_SZ    = 32,
    parameter int ADDRESS_SZ = 10
) (
    input  logic                  clk,
    input  logic                  rst,

    // requester port 0
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDRESS_SZ-1:0] addr0,
    input  logic [DATA_SZ-1:0]    wdata0,
    output logic                  ack0,
    output logic [DATA_SZ-1:0]    rdata0,

    // requester port 1
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDRESS_SZ-1:0] addr1,
    input  logic [DATA_SZ-1:0]    wdata1,
    output logic                  ack1,
    output logic [DATA_SZ-1:0]    rdata1,

    // memory side
    output logic [ADDRESS_SZ-1:0] mem_address,
    output logic [DATA_SZ-1:0]    mem_data_in,
    output logic                  mem_we,
    input  logic [DATA_SZ-1:0]    mem_data_out,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                  state;
    logic                    owner;      // port that owns the current transaction
    logic                    prio;       // port favoured when both request
    logic                    lat_we;
    logic [ADDRESS_SZ-1:0]   lat_addr;
    logic [DATA_SZ-1:0]      lat_wdata;
    logic                    grant;

    // Pick the port to serve: a lone requester always wins, a tie goes to prio.
    always_comb begin
        // NOTE: default assignment first so every path drives grant and no latch is inferred.
        grant = prio;
        if (req0 && !req1) begin
            grant = 1'b0;
        end else if (req1 && !req0) begin
            grant = 1'b1;
        end
    end

    // Transaction FSM: latch the winner's request, run one memory cycle, then ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= 1'b0;
            prio      <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            mem_we    <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        owner     <= grant;
                        lat_we    <= grant ? we1    : we0;
                        lat_addr  <= grant ? addr1  : addr0;
                        lat_wdata <= grant ? wdata1 : wdata0;
                        // mem_we mirrors the latched we for the ACCESS cycle only
                        mem_we    <= grant ? we1    : we0;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    // the write commits on this edge; a read result is captured now
                    mem_we <= 1'b0;
                    if (!lat_we) begin
                        if (owner) begin
                            rdata1 <= mem_data_out;
                        end else begin
                            rdata0 <= mem_data_out;
                        end
                    end
                    state <= RESP;
                end
                RESP: begin
                    prio  <= ~owner;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign ack0        = (state == RESP) && !owner;
    assign ack1        = (state == RESP) &&  owner;
    assign busy        = (state != IDLE);
    assign mem_address = lat_addr;
    assign mem_data_in = lat_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized self-checking bench for dmem_arbiter with a
// transaction-level reference model (ordering by the round-robin rule,
// fixed three-cycle timing, memory as an associative array).
module tb_dmem_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          ack0, ack1, busy, mem_we;
    logic [DW-1:0] rdata0, rdata1, mem_data_in, mem_data_out;
    logic [AW-1:0] mem_address;

    // bench-side datamemory: untouched words read a fixed address pattern
    logic [DW-1:0] mem [DEPTH];
    bit            written [DEPTH];

    // reference model state
    logic [DW-1:0] ref_mem [int];
    logic          ref_prio;
    logic [DW-1:0] ref_rdata [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.DATA_SZ(DW), .ADDRESS_SZ(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req0         (req0),
        .we0          (we0),
        .addr0        (addr0),
        .wdata0       (wdata0),
        .ack0         (ack0),
        .rdata0       (rdata0),
        .req1         (req1),
        .we1          (we1),
        .addr1        (addr1),
        .wdata1       (wdata1),
        .ack1         (ack1),
        .rdata1       (rdata1),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_we       (mem_we),
        .mem_data_out (mem_data_out),
        .busy         (busy)
    );

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return (DW'(a) * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    assign mem_data_out = written[mem_address] ? mem[mem_address] : init_val(mem_address);

    // datamemory write port
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_address]     <= mem_data_in;
            written[mem_address] <= 1'b1;
        end
    end

    function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
    endfunction

    function automatic logic get_ack(input int p);
        return (p == 0) ? ack0 : ack1;
    endfunction

    function automatic logic [DW-1:0] get_rdata(input int p);
        return (p == 0) ? rdata0 : rdata1;
    endfunction

    task automatic drive_port(input int p, input logic r, input logic w,
                              input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (p == 0) begin
            req0 = r; we0 = w; addr0 = a; wdata0 = d;
        end else begin
            req1 = r; we1 = w; addr1 = a; wdata1 = d;
        end
    endtask

    task automatic drop_req(input int p);
        if (p == 0) req0 = 1'b0;
        else        req1 = 1'b0;
    endtask

    task automatic model_reset();
        ref_prio     = 1'b0;
        ref_rdata[0] = '0;
        ref_rdata[1] = '0;
    endtask

    // Drive up to one request per port in the same cycle and check every
    // cycle until both are served and the arbiter is idle again. Starts and
    // ends just after a falling edge.
    task automatic run_pair(input bit v0, input bit w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                            input bit v1, input bit w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                            input string tag);
        bit            v [2];
        bit            w [2];
        logic [AW-1:0] a [2];
        logic [DW-1:0] d [2];
        logic [DW-1:0] rd_new [2];
        int            t [2];
        int            first, other, last, kmax, ap;
        logic          exp_bit;
        logic [DW-1:0] exp_rd;

        v[0] = v0; w[0] = w0; a[0] = a0; d[0] = d0;
        v[1] = v1; w[1] = w1; a[1] = a1; d[1] = d1;
        t[0] = -10; t[1] = -10;

        // order: tie -> priority port, otherwise the lone requester
        first = (v0 && v1) ? int'(ref_prio) : (v1 ? 1 : 0);
        other = 1 - first;
        t[first] = 2;
        if (v[other]) t[other] = 5;
        last = v[other] ? other : first;
        kmax = t[last] + 2;

        // memory effects in service order
        for (int i = 0; i < 2; i++) begin
            int p;
            p = (i == 0) ? first : other;
            rd_new[p] = ref_rdata[p];
            if (v[p]) begin
                if (w[p]) ref_mem[int'(a[p])] = d[p];
                else      rd_new[p] = ref_read(a[p]);
            end
        end

        for (int p = 0; p < 2; p++)
            drive_port(p, v[p], v[p] ? w[p] : 1'($urandom), v[p] ? a[p] : AW'($urandom),
                       v[p] ? d[p] : $urandom);

        for (int k = 1; k <= kmax; k++) begin
            @(posedge clk);
            #1;
            // inputs change after the latch edge; the arbiter must ignore them
            if (k == 1) drive_port(first, 1'b1, 1'($urandom), AW'($urandom), $urandom);
            for (int p = 0; p < 2; p++)
                if (v[p] && k == t[p] + 1) drop_req(p);
            @(negedge clk);

            ap = -1;
            for (int p = 0; p < 2; p++) begin
                exp_bit = v[p] && (k == t[p]);
                checks++;
                if (get_ack(p) !== exp_bit) begin
                    errors++;
                    $display("FAIL %s k=%0d ack%0d: got %b expected %b", tag, k, p, get_ack(p), exp_bit);
                end
                exp_rd = (v[p] && k >= t[p]) ? rd_new[p] : ref_rdata[p];
                checks++;
                if (get_rdata(p) !== exp_rd) begin
                    errors++;
                    $display("FAIL %s k=%0d rdata%0d: got %h expected %h", tag, k, p, get_rdata(p), exp_rd);
                end
                if (v[p] && k == t[p] - 1) ap = p;
            end

            exp_bit = (ap >= 0) && w[ap];
            checks++;
            if (mem_we !== exp_bit) begin
                errors++;
                $display("FAIL %s k=%0d mem_we: got %b expected %b", tag, k, mem_we, exp_bit);
            end
            if (ap >= 0) begin
                checks++;
                if (mem_address !== a[ap]) begin
                    errors++;
                    $display("FAIL %s k=%0d mem_address: got %h expected %h", tag, k, mem_address, a[ap]);
                end
                if (w[ap]) begin
                    checks++;
                    if (mem_data_in !== d[ap]) begin
                        errors++;
                        $display("FAIL %s k=%0d mem_data_in: got %h expected %h", tag, k, mem_data_in, d[ap]);
                    end
                end
            end

            exp_bit = 1'b0;
            for (int p = 0; p < 2; p++)
                if (v[p] && (k == t[p] || k == t[p] - 1)) exp_bit = 1'b1;
            checks++;
            if (busy !== exp_bit) begin
                errors++;
                $display("FAIL %s k=%0d busy: got %b expected %b", tag, k, busy, exp_bit);
            end
        end

        ref_rdata[0] = rd_new[0];
        ref_rdata[1] = rd_new[1];
        ref_prio     = ~1'(last);
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if ({ack0, ack1, busy, mem_we} !== 4'b0) begin
            errors++;
            $display("FAIL %s flags ack0/ack1/busy/mem_we: got %b expected 0000", tag, {ack0, ack1, busy, mem_we});
        end
        checks++;
        if ({rdata0, rdata1, mem_address, mem_data_in} !== '0) begin
            errors++;
            $display("FAIL %s data rdata0=%h rdata1=%h addr=%h din=%h expected all 0",
                     tag, rdata0, rdata1, mem_address, mem_data_in);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_port(0, 1'b0, 1'b0, '0, '0);
        drive_port(1, 1'b0, 1'b0, '0, '0);
        #1;
        check_all_zero("power_up");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_port0_write();
        run_pair(1'b1, 1'b1, AW'(3), DW'(6), 1'b0, 1'b0, '0, '0, "p0_write");
    endtask

    task automatic test_port1_read();
        run_pair(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, AW'(3), '0, "p1_read");
        checks++;
        if (rdata1 !== DW'(6)) begin
            errors++;
            $display("FAIL p1_read_value: got %h expected 6", rdata1);
        end
    endtask

    task automatic test_reset_mid();
        drive_port(1, 1'b1, 1'b0, AW'(3), '0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (ack1 !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid pre ack1: got %b expected 1", ack1);
        end
        rst = 1'b1;
        #1;
        check_all_zero("reset_mid");
        drop_req(1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({ack0, ack1, busy} !== 3'b0) begin
                errors++;
                $display("FAIL reset_mid post ack0/ack1/busy: got %b expected 000", {ack0, ack1, busy});
            end
        end
    endtask

    task automatic test_contention();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        run_pair(1'b1, 1'b1, AW'(20), DW'(32'hA0), 1'b1, 1'b1, AW'(21), DW'(32'hB1), "pair1");
        run_pair(1'b1, 1'b0, AW'(21), '0,          1'b1, 1'b0, AW'(20), '0,          "pair2");
        run_pair(1'b0, 1'b0, '0, '0,               1'b1, 1'b0, AW'(3),  '0,          "lone_req1");
    endtask

    task automatic test_reset_during_write();
        logic [DW-1:0] prior;
        prior = ref_read(AW'(4));
        drive_port(0, 1'b1, 1'b1, AW'(4), DW'(8));
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b1) begin
            errors++;
            $display("FAIL rst_write access mem_we: got %b expected 1", mem_we);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({mem_we, busy, ack0} !== 3'b0) begin
            errors++;
            $display("FAIL rst_write mem_we/busy/ack0: got %b expected 000", {mem_we, busy, ack0});
        end
        drop_req(0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (2) begin
            @(negedge clk);
            checks++;
            if ({ack0, busy} !== 2'b0) begin
                errors++;
                $display("FAIL rst_write no_ack ack0/busy: got %b expected 00", {ack0, busy});
            end
        end
        run_pair(1'b1, 1'b0, AW'(4), '0, 1'b0, 1'b0, '0, '0, "rst_write_readback");
        checks++;
        if (rdata0 !== prior) begin
            errors++;
            $display("FAIL rst_write readback: got %h expected %h (not 8)", rdata0, prior);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] exp_rd;
        logic          exp_ack;
        int            acks;
        exp_rd = ref_rdata[0];
        acks   = 0;
        drive_port(0, 1'b1, 1'b1, AW'(0), DW'(0));
        for (int k = 1; k <= 31; k++) begin
            @(posedge clk);
            #1;
            if (k >= 3 && (k - 3) % 3 == 0) begin
                int j;
                j = (k - 3) / 3 + 1;
                if (j < 5)       drive_port(0, 1'b1, 1'b1, AW'(j), DW'(2 * j));
                else if (j < 10) drive_port(0, 1'b1, 1'b0, AW'(j - 5), DW'($urandom));
                else             drop_req(0);
            end
            @(negedge clk);
            exp_ack = (k >= 2) && ((k - 2) % 3 == 0) && ((k - 2) / 3 < 10);
            checks++;
            if (ack0 !== exp_ack) begin
                errors++;
                $display("FAIL b2b k=%0d ack0: got %b expected %b", k, ack0, exp_ack);
            end
            if (exp_ack) begin
                int j;
                j = (k - 2) / 3;
                acks++;
                if (j >= 5) begin
                    exp_rd = DW'(2 * (j - 5));
                    checks++;
                    if (rdata0 !== exp_rd) begin
                        errors++;
                        $display("FAIL b2b read%0d rdata0: got %h expected %h", j - 5, rdata0, exp_rd);
                    end
                end
            end
            exp_ack = (k >= 1) && ((k - 1) % 3 == 0) && ((k - 1) / 3 < 5);
            checks++;
            if (mem_we !== exp_ack) begin
                errors++;
                $display("FAIL b2b k=%0d mem_we: got %b expected %b", k, mem_we, exp_ack);
            end
        end
        checks++;
        if (acks != 10) begin
            errors++;
            $display("FAIL b2b ack_count: got %0d expected 10", acks);
        end
        for (int i = 0; i < 5; i++) ref_mem[i] = DW'(2 * i);
        ref_rdata[0] = exp_rd;
        ref_prio     = 1'b1;
    endtask

    task automatic test_random();
        bit v0, v1;
        for (int n = 0; n < 25; n++) begin
            v0 = 1'($urandom);
            v1 = 1'($urandom);
            if (!v0 && !v1) v0 = 1'b1;
            run_pair(v0, 1'($urandom), AW'($urandom_range(0, 15)), $urandom,
                     v1, 1'($urandom), AW'($urandom_range(0, 15)), $urandom, "random");
        end
    endtask

    initial begin
        test_reset();
        test_port0_write();
        test_port1_read();
        test_reset_mid();
        test_contention();
        test_reset_during_write();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
